// File: rtl/mips_trace_buffer.sv
// Circular commit-trace buffer for the single-cycle MIPS core: PC-match trigger, post-trigger
// window capture and oldest-first readout. Define TRACE_FILTER_EN to record only writing cycles.
module mips_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int DATA_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic [DATA_W-1:0]          pc,
  input  logic [DATA_W-1:0]          instr,
  input  logic                       reg_we,
  input  logic [4:0]                 reg_addr,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       mem_we,
  input  logic [DATA_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic                       rd_last,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_instr,
  output logic [DATA_W-1:0]          rd_reg_data,
  output logic [DATA_W-1:0]          rd_mem_addr,
  output logic [DATA_W-1:0]          rd_mem_data,
  output logic                       rd_reg_we,
  output logic                       rd_mem_we,
  output logic [4:0]                 rd_reg_addr,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ARMED = 2'b01;
  localparam logic [1:0] S_POST  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              reg_we;
    logic [4:0]        reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t wr_entry;
  entry_t rd_entry_reg;

  logic [1:0]       state_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, post_cnt_reg, rd_left_reg;
  logic             rd_valid_reg, rd_last_reg;

  logic             qual, wr_en, trig_hit, rd_go;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [CNT_W-1:0] count_next, post_cnt_next;

`ifdef TRACE_FILTER_EN
  assign qual = reg_we | mem_we;
`else
  assign qual = 1'b1;
`endif

  assign wr_entry = '{pc: pc, instr: instr, reg_we: reg_we, reg_addr: reg_addr,
                      reg_data: reg_data, mem_we: mem_we, mem_addr: mem_addr,
                      mem_data: mem_data};

  always_comb begin
    // The arm cycle itself is never recorded.
    wr_en         = ((state_reg == S_ARMED) || (state_reg == S_POST)) && qual && !arm;
    trig_hit      = (state_reg == S_ARMED) && (pc == trig_pc);
    wr_ptr_next   = wr_ptr_reg + 1'b1;
    count_next    = (count_reg == DEPTH_C) ? count_reg : count_reg + 1'b1;
    post_cnt_next = post_cnt_reg + 1'b1;
    rd_go         = (state_reg == S_DONE) && rd_req && (rd_left_reg != '0) && !arm;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= wr_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      post_cnt_reg <= '0;
      rd_left_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_entry_reg <= '0;
    end else if (arm) begin
      state_reg    <= S_ARMED;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      post_cnt_reg <= '0;
      rd_left_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_next;
        count_reg  <= count_next;
        if (trig_hit) begin
          post_cnt_reg <= CNT_W'(1);
          state_reg    <= (POST_TRIG == 1) ? S_DONE : S_POST;
        end else if (state_reg == S_POST) begin
          post_cnt_reg <= post_cnt_next;
          if (post_cnt_next == POST_C)
            state_reg <= S_DONE;
        end
        // Oldest surviving entry: the window ends just before the next write slot.
        rd_ptr_reg  <= wr_ptr_next - count_next[PTR_W-1:0];
        rd_left_reg <= count_next;
      end
      if (rd_go) begin
        rd_valid_reg <= 1'b1;
        rd_last_reg  <= (rd_left_reg == CNT_W'(1));
        rd_entry_reg <= mem[rd_ptr_reg];
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        rd_left_reg  <= rd_left_reg - 1'b1;
      end
    end
  end

  assign state       = state_reg;
  assign count       = count_reg;
  assign rd_valid    = rd_valid_reg;
  assign rd_last     = rd_last_reg;
  assign rd_pc       = rd_entry_reg.pc;
  assign rd_instr    = rd_entry_reg.instr;
  assign rd_reg_we   = rd_entry_reg.reg_we;
  assign rd_reg_addr = rd_entry_reg.reg_addr;
  assign rd_reg_data = rd_entry_reg.reg_data;
  assign rd_mem_we   = rd_entry_reg.mem_we;
  assign rd_mem_addr = rd_entry_reg.mem_addr;
  assign rd_mem_data = rd_entry_reg.mem_data;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the capture window.
module tb_mips_trace_buffer;

  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;
  localparam int DW        = 32;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic          reg_we;
    logic [4:0]    reg_addr;
    logic [DW-1:0] reg_data;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic [DW-1:0] trig_pc = '0, pc = '0, instr = '0;
  logic          reg_we = 1'b0, mem_we = 1'b0, rd_req = 1'b0;
  logic [4:0]    reg_addr = '0;
  logic [DW-1:0] reg_data = '0, mem_addr = '0, mem_data = '0;

  logic          rd_valid, rd_last, rd_reg_we, rd_mem_we;
  logic [DW-1:0] rd_pc, rd_instr, rd_reg_data, rd_mem_addr, rd_mem_data;
  logic [4:0]    rd_reg_addr;
  logic [1:0]    state;
  logic [4:0]    count;

  logic          d1_rd_valid, d1_rd_last, d1_rd_reg_we, d1_rd_mem_we;
  logic [DW-1:0] d1_rd_pc, d1_rd_instr, d1_rd_reg_data, d1_rd_mem_addr, d1_rd_mem_data;
  logic [4:0]    d1_rd_reg_addr;
  logic [1:0]    d1_state;
  logic [2:0]    d1_count;

  int tests_run = 0;
  int fails = 0;

  // Reference model: the captured window as a queue of at most DEPTH entries.
  ent_t m_q[$];
  int   m_state = 0;
  int   m_post = 0;
  int   m_rd = 0;
  logic exp_valid = 1'b0, exp_last = 1'b0;
  ent_t exp_ent;

  always #5 clk = ~clk;

  mips_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .pc(pc), .instr(instr),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .rd_req(rd_req), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_reg_data(rd_reg_data),
    .rd_mem_addr(rd_mem_addr), .rd_mem_data(rd_mem_data), .rd_reg_we(rd_reg_we),
    .rd_mem_we(rd_mem_we), .rd_reg_addr(rd_reg_addr), .state(state), .count(count));

  mips_trace_buffer #(.DEPTH(4), .POST_TRIG(1), .DATA_W(DW)) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc), .pc(pc), .instr(instr),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .rd_req(rd_req), .rd_valid(d1_rd_valid),
    .rd_last(d1_rd_last), .rd_pc(d1_rd_pc), .rd_instr(d1_rd_instr),
    .rd_reg_data(d1_rd_reg_data), .rd_mem_addr(d1_rd_mem_addr), .rd_mem_data(d1_rd_mem_data),
    .rd_reg_we(d1_rd_reg_we), .rd_mem_we(d1_rd_mem_we), .rd_reg_addr(d1_rd_reg_addr),
    .state(d1_state), .count(d1_count));

  function automatic ent_t dut_ent();
    return {rd_pc, rd_instr, rd_reg_we, rd_reg_addr, rd_reg_data, rd_mem_we, rd_mem_addr, rd_mem_data};
  endfunction

  function automatic logic qualifies();
`ifdef TRACE_FILTER_EN
    return reg_we | mem_we;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: advance the model with the inputs seen at the edge, return 1 time unit later.
  task automatic tick();
    ent_t cur;
    @(posedge clk);
    cur = {pc, instr, reg_we, reg_addr, reg_data, mem_we, mem_addr, mem_data};
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    if (reset) begin
      m_state = 0; m_q.delete(); m_post = 0; m_rd = 0;
    end else if (arm) begin
      m_state = 1; m_q.delete(); m_post = 0; m_rd = 0;
    end else if ((m_state == 1 || m_state == 2) && qualifies()) begin
      m_q.push_back(cur);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      if (m_state == 1 && pc == trig_pc) begin
        m_post = 1;
        m_state = (POST_TRIG == 1) ? 3 : 2;
      end else if (m_state == 2) begin
        m_post++;
        if (m_post == POST_TRIG) m_state = 3;
      end
    end else if (m_state == 3 && rd_req && m_rd < m_q.size()) begin
      exp_valid = 1'b1;
      exp_ent   = m_q[m_rd];
      exp_last  = (m_rd == m_q.size() - 1);
      m_rd++;
    end
    #1;
  endtask

  task automatic rand_payload(input logic we);
    instr    = $urandom;
    reg_we   = we;
    reg_addr = 5'($urandom);
    reg_data = $urandom;
    mem_we   = 1'($urandom);
    mem_addr = $urandom;
    mem_data = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'b00 || count !== 5'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_pc !== '0) begin
      fails++;
      $display("FAIL reset_values got state=%b count=%0d valid=%b last=%b pc=%h need 00/0/0/0/0",
               state, count, rd_valid, rd_last, rd_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset values checked");
  endtask

  task automatic test_reset_mid();
    arm = 1'b1; trig_pc = 32'hFFFF_0000;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc = 32'h900 + 4 * i; rand_payload(1'b1);
      tick();
    end
    tests_run++;
    if (count !== 5'd5 || state !== 2'b01) begin
      fails++;
      $display("FAIL pre_reset_count got count=%0d state=%b need 5/01", count, state);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (state !== 2'b00 || count !== 5'd0 || rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got state=%b count=%0d valid=%b need 00/0/0", state, count, rd_valid);
    end
    m_state = 0; m_q.delete(); m_post = 0; m_rd = 0;
    @(negedge clk);
    reset = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (rd_valid !== 1'b0 || state !== 2'b00) begin
        fails++;
        $display("FAIL req_after_reset got valid=%b state=%b need 0/00", rd_valid, state);
      end
    end
    rd_req = 1'b0;
    $display("[TB] reset mid-capture checked");
  endtask

  task automatic test_full_window();
    arm = 1'b1; trig_pc = 32'h40; pc = 32'h0;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 40 && m_state != 3; i++) begin
      pc = 4 * i; rand_payload(1'b1);
      tick();
      tests_run++;
      if (state !== 2'(m_state) || count !== 5'(m_q.size())) begin
        fails++;
        $display("FAIL capture_step pc=%h got state=%b count=%0d need %0d/%0d",
                 pc, state, count, m_state, m_q.size());
      end
    end
    tests_run++;
    if (state !== 2'b11 || count !== 5'd16) begin
      fails++;
      $display("FAIL window_done got state=%b count=%0d need 11/16", state, count);
    end
    rd_req = 1'b1;
    for (int i = 0; i < 17; i++) begin
      pc = 32'h1000;
      tick();
      tests_run++;
      if (i < 16) begin
        if (rd_valid !== 1'b1 || rd_pc !== 32'h10 + 4 * i || rd_last !== (i == 15) || dut_ent() !== exp_ent) begin
          fails++;
          $display("FAIL readout_%0d got valid=%b pc=%h last=%b need 1/%h/%b",
                   i, rd_valid, rd_pc, rd_last, 32'h10 + 4 * i, (i == 15));
        end
      end else if (rd_valid !== 1'b0) begin
        fails++;
        $display("FAIL extra_req got valid=%b need 0", rd_valid);
      end
      $display("[TB] readout %0d valid=%b pc=%h last=%b", i, rd_valid, rd_pc, rd_last);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_no_trigger_rearm();
    arm = 1'b1; trig_pc = 32'h200;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h100 + 4 * i; rand_payload(1'b1);
      tick();
    end
    tests_run++;
    if (count !== 5'd3 || state !== 2'b01) begin
      fails++;
      $display("FAIL no_trig_count got count=%0d state=%b need 3/01", count, state);
    end
    arm = 1'b1; pc = 32'h200; rand_payload(1'b1);
    tick();
    tests_run++;
    if (state !== 2'b01 || count !== 5'd0) begin
      fails++;
      $display("FAIL rearm got state=%b count=%0d need 01/0", state, count);
    end
    arm = 1'b0; pc = 32'h300;
    tick();
    tests_run++;
    if (state !== 2'b01 || count !== 5'd1) begin
      fails++;
      $display("FAIL arm_cycle_ignored got state=%b count=%0d need 01/1", state, count);
    end
    $display("[TB] rearm without trigger checked");
  endtask

  task automatic test_post_trig_one();
    arm = 1'b1; trig_pc = 32'h500; pc = 32'h500;
    tick();
    arm = 1'b0; rand_payload(1'b1);
    tick();
    tests_run++;
    if (d1_state !== 2'b11 || d1_count !== 3'd1) begin
      fails++;
      $display("FAIL post1_done got state=%b count=%0d need 11/1", d1_state, d1_count);
    end
    pc = 32'h504; rd_req = 1'b1;
    tick();
    tests_run++;
    if (d1_rd_valid !== 1'b1 || d1_rd_last !== 1'b1 || d1_rd_pc !== 32'h500) begin
      fails++;
      $display("FAIL post1_read got valid=%b last=%b pc=%h need 1/1/500", d1_rd_valid, d1_rd_last, d1_rd_pc);
    end
    tick();
    tests_run++;
    if (d1_rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL post1_extra got valid=%b need 0", d1_rd_valid);
    end
    rd_req = 1'b0;
    $display("[TB] single-entry window checked");
  endtask

  task automatic test_gapped_readout();
    logic req_pat [5];
    int   k;
    req_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    arm = 1'b1; trig_pc = 32'h720;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 20 && m_state != 3; i++) begin
      pc = 32'h700 + 4 * i; rand_payload(1'b1);
      tick();
    end
    k = 0;
    for (int i = 0; i < 5; i++) begin
      rd_req = req_pat[i];
      tick();
      tests_run++;
      if (rd_valid !== req_pat[i] || (req_pat[i] && (rd_pc !== 32'h700 + 4 * k || dut_ent() !== exp_ent))) begin
        fails++;
        $display("FAIL gapped_%0d got valid=%b pc=%h need %b/%h", i, rd_valid, rd_pc, req_pat[i], 32'h700 + 4 * k);
      end
      $display("[TB] gapped req=%b valid=%b pc=%h", req_pat[i], rd_valid, rd_pc);
      if (req_pat[i]) k++;
    end
    rd_req = 1'b0;
  endtask

`ifdef TRACE_FILTER_EN
  task automatic test_filter();
    arm = 1'b1; trig_pc = 32'h604;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pc = 32'h600 + 4 * i; instr = $urandom; mem_we = 1'b0;
      reg_we = (i % 2 == 0); reg_addr = 5'd8; reg_data = 32'h5;
      tick();
    end
    tests_run++;
    if (state !== 2'b01 || count !== 5'd6) begin
      fails++;
      $display("FAIL filter_capture got state=%b count=%0d need 01/6", state, count);
    end
    trig_pc = 32'h630;
    for (int i = 12; i < 40 && m_state != 3; i++) begin
      pc = 32'h600 + 4 * i; reg_we = (i % 2 == 0);
      tick();
    end
    tests_run++;
    if (state !== 2'b11 || count !== 5'd10) begin
      fails++;
      $display("FAIL filter_done got state=%b count=%0d need 11/10", state, count);
    end
    rd_req = 1'b1; reg_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_reg_addr !== 5'd8 || rd_reg_data !== 32'h5 || rd_pc !== 32'h600 + 8 * i) begin
        fails++;
        $display("FAIL filter_read_%0d got valid=%b addr=%0d data=%h pc=%h need 1/8/5/%h",
                 i, rd_valid, rd_reg_addr, rd_reg_data, rd_pc, 32'h600 + 8 * i);
      end
    end
    rd_req = 1'b0;
    $display("[TB] filtered capture checked");
  endtask
`endif

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      trig_pc = 32'h100 + 4 * $urandom_range(0, 15);
      for (int c = 0; c < 80; c++) begin
        arm    = (c == 0) || ($urandom_range(0, 39) == 0);
        pc     = 32'h100 + 4 * $urandom_range(0, 15);
        rand_payload(1'($urandom));
        rd_req = 1'($urandom);
        tick();
        tests_run++;
        if (state !== 2'(m_state) || count !== 5'(m_q.size()) || rd_valid !== exp_valid ||
            rd_last !== exp_last || (exp_valid && dut_ent() !== exp_ent)) begin
          fails++;
          $display("FAIL random_r%0d_c%0d got st=%b cnt=%0d v=%b l=%b ent=%h need %0d/%0d/%b/%b/%h",
                   r, c, state, count, rd_valid, rd_last, dut_ent(), m_state, m_q.size(),
                   exp_valid, exp_last, exp_ent);
        end
      end
      $display("[TB] random round %0d trig=%h final state=%b count=%0d", r, trig_pc, state, count);
    end
    arm = 1'b0; rd_req = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_reset_mid();
    test_full_window();
    test_no_trigger_rearm();
    test_post_trig_one();
    test_gapped_readout();
`ifdef TRACE_FILTER_EN
    test_filter();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

- Synthesizable on-chip trace buffer for the single-cycle MIPS core.
- Records per-cycle commit information into a circular buffer: PC, instruction, register-file write and data-memory write.
- Freezes capture a configurable number of entries after a PC-match trigger, then plays the window back oldest-first over a request/valid readout port.
- Sits beside `main_mips`, tapping its PC, instruction and write-back/memory-write nets, so the same debug visibility the simulation benches provide is available in hardware.

## Interface
Parameters:
- DEPTH, 16, buffer entries; power of two, ≥ 4
- POST_TRIG, 4, entries captured from the trigger entry onward, inclusive; 1..DEPTH
- DATA_W, 32, width of pc, instr, data and address fields

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- arm  in  1  single-cycle pulse; starts a new capture
- trig_pc  in  DATA_W  PC value that fires the trigger
- pc, instr  in  DATA_W  current core PC / instruction
- reg_we  in  1  register-file write enable
- reg_addr  in  5  register-file write address
- reg_data  in  DATA_W  register-file write data
- mem_we  in  1  data-memory write enable
- mem_addr, mem_data  in  DATA_W  data-memory write address/data
- rd_req  in  1  readout request, one entry per asserted cycle
- rd_valid  out  1  readout entry valid
- rd_last  out  1  entry is the newest in the window
- rd_pc, rd_instr, rd_reg_data, rd_mem_addr, rd_mem_data  out  DATA_W  entry fields
- rd_reg_we, rd_mem_we  out  1  entry fields
- rd_reg_addr  out  5  entry field
- state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
- count  out  $clog2(DEPTH)+1  valid entries held, saturating at DEPTH

## Operation
- IDLE: no capture.
  - arm → ARMED; wr_ptr, count and post counter cleared.
- ARMED: every qualifying cycle is written at wr_ptr; wr_ptr increments modulo DEPTH; count saturates at DEPTH, overwriting the oldest entry.
  - A qualifying cycle with pc == trig_pc stores the trigger entry, sets the post counter to 1, and moves to POST, or to DONE if POST_TRIG == 1.
- POST: qualifying cycles are stored and the post counter increments.
  - When the post counter reaches POST_TRIG on a store → DONE.
  - A PC match in POST is not a new trigger.
- DONE: capture frozen; rd_ptr = (wr_ptr − count) mod DEPTH.
  - rd_req with entries remaining → entry at rd_ptr is presented next cycle; rd_ptr increments.
  - rd_last accompanies the entry at wr_ptr−1.
  - rd_req after the last entry, or in any state other than DONE, is ignored: rd_valid stays 0.
- arm in any state restarts at ARMED and aborts any readout in progress.
  - The arm cycle itself is never captured, even if its PC matches.
- Qualifying cycle: see Configuration.

## Timing
- Reset values:
  - state = IDLE, count = 0, rd_valid = 0, rd_last = 0.
  - All rd_* data = 0; pointers = 0.
  - Buffer contents are undefined and never readable before being written.
- Capture is sampled on the rising edge; an entry written at edge N is counted in `count` from N+1.
- Trigger detection is same-cycle: the trigger cycle's entry is stored at that edge, and state shows POST/DONE from the next cycle.
- Readout latency is 1 cycle: rd_req high at edge N → rd_valid high for the cycle after N with data registered.
  - Back-to-back rd_req streams one entry per cycle.
  - rd_valid drops the cycle after the final entry unless further requests exist (they are ignored).
- Reset asserted mid-capture or mid-readout: outputs go to reset values immediately (asynchronous); operation resumes in IDLE.

## Configuration
- TRACE_FILTER_EN defined: a cycle qualifies only if reg_we | mem_we.
  - The trigger PC match also requires a qualifying cycle.
  - Non-writing instructions (branches, stores to $0 excluded by reg_we) consume no entries.
- TRACE_FILTER_EN undefined: every cycle qualifies; the buffer is a full PC/instruction history.

## Test plan
- Reset mid-ARMED with count=5 → state=00, count=0, rd_valid=0 immediately; no rd_valid on subsequent rd_req.
- DEPTH=16, POST_TRIG=4, unfiltered, PC stepping by 4 from 0x0, trig_pc=0x40 → DONE after PC 0x4C stored.
  - count=16; readout yields PCs 0x10..0x4C in order.
  - rd_last only on 0x4C; a 17th rd_req gives no rd_valid.
- Trigger never reached: 3 entries captured, then arm → state=ARMED, count=0; the match on the arm cycle is ignored.
- POST_TRIG=1, trig_pc equal to the first qualifying PC → DONE after one cycle; count=1; single readout with rd_valid and rd_last both 1.
- With TRACE_FILTER_EN: stream alternating reg_we=1 (addr 8, data 0x5) and non-writing cycles → only writing cycles stored.
  - rd_reg_addr=8, rd_reg_data=0x00000005.
  - A trig_pc on a non-writing cycle does not trigger.
- Readout with rd_req gapped (1,0,1,1) → rd_valid follows one cycle later (0,1,0,1,1); entries are in order with none skipped.
